// File: rtl/ga_seq_pkg.sv
// rtl/ga_seq_pkg.sv - shared phase, slot and arbitration definitions for the gate array sequencer
package ga_seq_pkg;

   localparam int         PHASES   = 16;
   localparam int         SLOT_LEN = 4;
   localparam logic [3:0] V0_START = 4'd0;
   localparam logic [3:0] V1_START = 4'd4;

   // Johnson codes for phases p0..p15
   localparam logic [7:0] JOHNSON_CODE [PHASES] = '{
      8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
      8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80
   };

   typedef enum logic [1:0] {SLOT_V0, SLOT_V1, SLOT_CPU, SLOT_IDLE} slot_t;

   typedef enum logic [1:0] {ARB_IDLE, ARB_PEND, ARB_SVC} arb_t;

   // Slots are 4-phase aligned, so the upper two phase bits select the slot
   function automatic slot_t slot_of(input logic [3:0] ph, input logic [3:0] cpu_start);
      slot_t r;
      r = SLOT_IDLE;
      if (ph[3:2] == V0_START[3:2])
         r = SLOT_V0;
      else if (ph[3:2] == V1_START[3:2])
         r = SLOT_V1;
      else if (ph[3:2] == cpu_start[3:2])
         r = SLOT_CPU;
      return r;
   endfunction

endpackage

// File: rtl/ga_sequencer_if.sv
// rtl/ga_sequencer_if.sv - CPU/CRTC request inputs and timing/strobe outputs of the sequencer
interface ga_sequencer_if;

   logic       cpu_req;
   logic       hsync;
   logic [7:0] s;
   logic       phi_n;
   logic       cclk;
   logic       ras_n;
   logic       cas_n;
   logic       cpu_addr_sel;
   logic       vid_latch;
   logic       ready;
   logic       mode_sync;
   logic       seq_err;

   modport master (
      input  cpu_req, hsync,
      output s, phi_n, cclk, ras_n, cas_n, cpu_addr_sel, vid_latch, ready, mode_sync, seq_err
   );

   modport slave (
      output cpu_req, hsync,
      input  s, phi_n, cclk, ras_n, cas_n, cpu_addr_sel, vid_latch, ready, mode_sync, seq_err
   );

endinterface

// File: rtl/ga_johnson8.sv
// rtl/ga_johnson8.sv - 8-bit Johnson sequencer and phase decode; GA_SEQ_CHECK_EN adds the legality check
module ga_johnson8
   import ga_seq_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] s,
   output logic [3:0] p,
   output logic       illegal,
   output logic       seq_err
);

`ifdef GA_SEQ_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic hit;

   // Map the current code onto its phase number; codes outside the table report no hit
   always_comb begin
      p   = 4'd0;
      hit = 1'b0;
      for (int i = 0; i < PHASES; i++) begin
         if (s == JOHNSON_CODE[i]) begin
            p   = 4'(i);
            hit = 1'b1;
         end
      end
   end

   assign illegal = CHECK_EN & ~hit;

   // Twisted-ring shift; an illegal code is pulled back to p0 with a one-cycle error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         s       <= 8'h00;
         seq_err <= 1'b0;
      end else if (illegal) begin
         s       <= 8'h00;
         seq_err <= 1'b1;
      end else begin
         s       <= {s[6:0], ~s[7]};
         seq_err <= 1'b0;
      end
   end

endmodule

// File: rtl/ga_sequencer.sv
// rtl/ga_sequencer.sv - gate array master timing, DRAM slot arbitration and mode commit (GA_SEQ_CHECK_EN in ga_johnson8)
module ga_sequencer
   import ga_seq_pkg::*;
#(
   parameter int CPU_SLOT_START    = 8,
   parameter int HSYNC_SYNC_STAGES = 2
)(
   input  logic           clk_n,
   input  logic           reset,
   ga_sequencer_if.master bus
);

   localparam logic [3:0] CPU_START = 4'(CPU_SLOT_START);
   localparam logic [3:0] CPU_END   = 4'(CPU_SLOT_START + SLOT_LEN - 1);

   if ((CPU_SLOT_START != 8 && CPU_SLOT_START != 12) || HSYNC_SYNC_STAGES < 2) begin : g_bad_cfg
      $error("ga_sequencer: CPU_SLOT_START must be 8 or 12 and HSYNC_SYNC_STAGES at least 2");
   end

   logic [3:0]                   p;
   logic                         illegal;
   arb_t                         arb, arb_n;
   logic                         req_q, rise, cpu_active;
   slot_t                        slot;
   logic [1:0]                   off;
   logic                         video, act;
   logic [HSYNC_SYNC_STAGES-1:0] h_sync;
   logic                         h_prev, h_fall, mode_pend;

   ga_johnson8 u_john (
      .clk     (clk_n),
      .reset   (reset),
      .s       (bus.s),
      .p       (p),
      .illegal (illegal),
      .seq_err (bus.seq_err)
   );

   assign h_fall = h_prev & ~h_sync[HSYNC_SYNC_STAGES-1];

   // CPU request FSM next state and qualification of the current slot's DRAM strobes
   always_comb begin
      rise       = bus.cpu_req & ~req_q;
      arb_n      = arb;
      cpu_active = 1'b0;
      slot       = slot_of(p, CPU_START);
      off        = p[1:0];
      if (!bus.cpu_req) begin
         arb_n = ARB_IDLE;
      end else begin
         case (arb)
            ARB_IDLE: begin
               if (rise) begin
                  if (p == CPU_START) begin
                     arb_n      = ARB_SVC;
                     cpu_active = 1'b1;
                  end else begin
                     arb_n = ARB_PEND;
                  end
               end
            end
            ARB_PEND: begin
               if (p == CPU_START) begin
                  arb_n      = ARB_SVC;
                  cpu_active = 1'b1;
               end
            end
            ARB_SVC: begin
               cpu_active = 1'b1;
               if (p == CPU_END)
                  arb_n = ARB_IDLE;
            end
            default: arb_n = ARB_IDLE;
         endcase
      end
      // A sequencer upset aborts an in-flight access but keeps the request pending
      if (illegal && arb_n == ARB_SVC)
         arb_n = ARB_PEND;
      video = (slot == SLOT_V0) || (slot == SLOT_V1);
      act   = !illegal && (video || (slot == SLOT_CPU && cpu_active));
   end

   // Registered clocks, strobes, READY and arbitration state
   always_ff @(posedge clk_n) begin
      if (reset) begin
         arb              <= ARB_IDLE;
         req_q            <= 1'b0;
         bus.phi_n        <= 1'b1;
         bus.cclk         <= 1'b1;
         bus.ras_n        <= 1'b1;
         bus.cas_n        <= 1'b1;
         bus.cpu_addr_sel <= 1'b0;
         bus.vid_latch    <= 1'b0;
         bus.ready        <= 1'b1;
      end else begin
         arb              <= arb_n;
         req_q            <= bus.cpu_req;
         bus.phi_n        <= p[1];
         bus.cclk         <= ~p[3];
         bus.ras_n        <= ~(act && off != 2'd3);
         bus.cas_n        <= ~(act && (off == 2'd1 || off == 2'd2));
         bus.cpu_addr_sel <= act && slot == SLOT_CPU;
         bus.vid_latch    <= act && video && off == 2'd2;
         bus.ready        <= (arb_n == ARB_IDLE);
      end
   end

   // HSYNC synchroniser and mode commit pulse aligned to the end of the microsecond
   always_ff @(posedge clk_n) begin
      if (reset) begin
         h_sync        <= '0;
         h_prev        <= 1'b0;
         mode_pend     <= 1'b0;
         bus.mode_sync <= 1'b0;
      end else begin
         h_sync <= {h_sync[HSYNC_SYNC_STAGES-2:0], bus.hsync};
         h_prev <= h_sync[HSYNC_SYNC_STAGES-1];
         if (p == 4'd15) begin
            bus.mode_sync <= mode_pend | h_fall;
            mode_pend     <= 1'b0;
         end else begin
            bus.mode_sync <= 1'b0;
            if (h_fall)
               mode_pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ga_sequencer.sv
// tb/tb_ga_sequencer.sv - directed-vector bench for ga_sequencer
module tb_ga_sequencer;

   logic clk_n = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   logic [7:0] codes [16] = '{
      8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
      8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80
   };

   ga_sequencer_if bus();

   ga_sequencer #(.CPU_SLOT_START(8), .HSYNC_SYNC_STAGES(2)) dut (
      .clk_n (clk_n),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk_n = ~clk_n;

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_n);
      cyc++;
      @(negedge clk_n);
   endtask

   task automatic run_to(input int k);
      for (int n = 0; n < 16 && (cyc % 16) != k; n++)
         tick();
   endtask

   task automatic do_reset();
      bus.cpu_req = 1'b0;
      bus.hsync   = 1'b1;
      reset       = 1'b1;
      @(posedge clk_n);
      @(posedge clk_n);
      @(negedge clk_n);
      reset = 1'b0;
      cyc   = 0;
   endtask

   function automatic logic [16:0] outs();
      return {bus.s, bus.phi_n, bus.cclk, bus.ras_n, bus.cas_n, bus.cpu_addr_sel,
              bus.vid_latch, bus.ready, bus.mode_sync, bus.seq_err};
   endfunction

   task automatic sweep(output logic [15:0] cclk_v, output logic [15:0] phi_v,
                        output logic [15:0] ras_v, output logic [15:0] cas_v,
                        output logic [15:0] vid_v, output logic [15:0] sel_v,
                        output logic [15:0] rdy_v);
      int k;
      for (int n = 0; n < 16; n++) begin
         k = cyc % 16;
         cclk_v[k] = bus.cclk;
         phi_v[k]  = bus.phi_n;
         ras_v[k]  = bus.ras_n;
         cas_v[k]  = bus.cas_n;
         vid_v[k]  = bus.vid_latch;
         sel_v[k]  = bus.cpu_addr_sel;
         rdy_v[k]  = bus.ready;
         tick();
      end
   endtask

   task automatic mode_run(input int back_hi, input int back_lo, output int pulses, output int pos);
      bus.hsync = 1'b1;
      for (int n = 0; n < 4; n++)
         tick();
      run_to(4);
      bus.hsync = 1'b0;
      pulses = 0;
      pos    = -1;
      for (int i = 0; i < 28; i++) begin
         if (i == back_hi) bus.hsync = 1'b1;
         if (i == back_lo) bus.hsync = 1'b0;
         tick();
         if (bus.mode_sync) begin
            pulses++;
            pos = cyc % 16;
         end
      end
   endtask

   initial begin
      logic [15:0] cclk_v, phi_v, ras_v, cas_v, vid_v, sel_v, rdy_v;
      int low_cnt, sel_cnt, pulses, pos, err_cnt;

      do_reset();
      check_vec("reset_outputs", 32'(outs()), {15'd0, 8'h00, 9'b111100100});

      for (int i = 0; i < 32; i++) begin
         check_vec($sformatf("s_seq_%0d", i), 32'(bus.s), 32'(codes[i % 16]));
         tick();
      end

      sweep(cclk_v, phi_v, ras_v, cas_v, vid_v, sel_v, rdy_v);
      check_vec("idle_cclk",  32'(cclk_v), 32'h01FE);
      check_vec("idle_phi_n", 32'(phi_v),  32'h9999);
      check_vec("idle_ras_n", 32'(ras_v),  32'hFF11);
      check_vec("idle_cas_n", 32'(cas_v),  32'hFF33);
      check_vec("idle_vid",   32'(vid_v),  32'h0088);
      check_vec("idle_sel",   32'(sel_v),  32'h0000);
      check_vec("idle_ready", 32'(rdy_v),  32'hFFFF);

      run_to(3);
      bus.cpu_req = 1'b1;
      tick();
      sweep(cclk_v, phi_v, ras_v, cas_v, vid_v, sel_v, rdy_v);
      check_vec("p3_ready", 32'(rdy_v), 32'hF00F);
      check_vec("p3_sel",   32'(sel_v), 32'h1E00);
      check_vec("p3_ras_n", 32'(ras_v), 32'hF111);
      check_vec("p3_cas_n", 32'(cas_v), 32'hF333);
      check_vec("p3_vid",   32'(vid_v), 32'h0088);
      low_cnt = 0;
      for (int n = 0; n < 16; n++) begin
         if (!bus.ready) low_cnt++;
         tick();
      end
      check_vec("held_req_ready_low", 32'(low_cnt), 32'd0);

      bus.cpu_req = 1'b0;
      tick();
      run_to(9);
      bus.cpu_req = 1'b1;
      low_cnt = 0;
      sel_cnt = 0;
      for (int n = 0; n < 32; n++) begin
         tick();
         if (!bus.ready) low_cnt++;
         if (bus.cpu_addr_sel) sel_cnt++;
      end
      check_vec("p9_ready_low_cycles", 32'(low_cnt), 32'd18);
      check_vec("p9_sel_cycles",       32'(sel_cnt), 32'd4);

      bus.cpu_req = 1'b0;
      tick();
      run_to(3);
      bus.cpu_req = 1'b1;
      tick();
      check_vec("cancel_ready_wait", 32'(bus.ready), 32'd0);
      run_to(5);
      bus.cpu_req = 1'b0;
      tick();
      check_vec("cancel_ready_back", 32'(bus.ready), 32'd1);
      sel_cnt = 0;
      for (int n = 0; n < 16; n++) begin
         tick();
         if (bus.cpu_addr_sel) sel_cnt++;
      end
      check_vec("cancel_no_service", 32'(sel_cnt), 32'd0);

      run_to(3);
      bus.cpu_req = 1'b1;
      run_to(10);
      check_vec("mid_access", 32'({bus.ras_n, bus.cpu_addr_sel, bus.ready}), 32'b010);
      reset = 1'b1;
      @(posedge clk_n);
      @(negedge clk_n);
      check_vec("mid_access_reset", 32'(outs()), {15'd0, 8'h00, 9'b111100100});

      do_reset();
      mode_run(-1, -1, pulses, pos);
      check_vec("mode_single_count", 32'(pulses), 32'd1);
      check_vec("mode_single_phase", 32'(pos),    32'd0);
      mode_run(2, 5, pulses, pos);
      check_vec("mode_merge_count",  32'(pulses), 32'd1);
      check_vec("mode_merge_phase",  32'(pos),    32'd0);

      do_reset();
      run_to(5);
      force dut.u_john.s = 8'h55;
      #1;
      release dut.u_john.s;
      tick();
`ifdef GA_SEQ_CHECK_EN
      check_vec("seq_err_set",   32'({bus.s, bus.seq_err}), {23'd0, 8'h00, 1'b1});
      tick();
      check_vec("seq_err_clear", 32'({bus.s, bus.seq_err}), {23'd0, 8'h01, 1'b0});
`else
      err_cnt = 0;
      for (int n = 0; n < 8; n++) begin
         if (bus.seq_err) err_cnt++;
         tick();
      end
      check_vec("seq_err_disabled", 32'(err_cnt), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
